// File: rtl/ita_activation_stream_if.sv
// Beat handshake for the ITA activation stream: valid/ready, lane data and
// the per-beat activation mode that travels with it.
interface ita_activation_stream_if #(
    parameter int unsigned LANES  = 16,
    parameter int unsigned DATA_W = 8
);
    logic                      valid;
    logic                      ready;
    logic [LANES*DATA_W-1:0]   data;
    logic [1:0]                activation;

    modport master (output valid, output data, output activation, input ready);
    modport slave  (input valid, input data, input activation, output ready);
endinterface

// File: rtl/ita_activation_stream.sv
// Streaming IDENTITY / RELU / GELU activation unit, 3-stage elastic pipeline
// with full backpressure. S1 computes the GELU polynomial, S2 the full
// precision GELU product, S3 requantises/selects and drives the output flops.
// Optional: define ITA_ACTIVATION_STREAM_SAT_CNT_EN to add the sticky GELU
// saturation counter (sat_cnt_o) and its clear input (sat_clr_i).
module ita_activation_stream #(
    parameter int unsigned LANES   = 16,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned CONST_W = 16,
    parameter int unsigned RQ_W    = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    ita_activation_stream_if.slave     upstream,
    ita_activation_stream_if.master    downstream,
    input  logic signed [CONST_W-1:0]  one_i,
    input  logic signed [CONST_W-1:0]  b_i,
    input  logic signed [CONST_W-1:0]  c_i,
    input  logic        [RQ_W-1:0]     requant_mult_i,
    input  logic        [RQ_W-1:0]     requant_shift_i,
    input  logic signed [RQ_W-1:0]     requant_add_i,
`ifdef ITA_ACTIVATION_STREAM_SAT_CNT_EN
    input  logic                       sat_clr_i,
    output logic        [15:0]         sat_cnt_o,
`endif
    output logic                       busy_o
);

    // Internal widths are sized so that no intermediate can overflow.
    localparam int unsigned AW = ((DATA_W > CONST_W) ? DATA_W : CONST_W) + 2; // |x|, -b, a
    localparam int unsigned SW = AW + 1;                                      // a + b
    localparam int unsigned EW = 2 * SW + 2;                                  // p, e, e + one
    localparam int unsigned GW = DATA_W + EW + 1;                             // g
    localparam int unsigned MW = GW + RQ_W + 2;                               // g*mult + round
    localparam int unsigned DW = LANES * DATA_W;

    localparam logic signed [MW-1:0] SAT_HI = MW'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [MW-1:0] SAT_LO = MW'(-(2 ** (DATA_W - 1)));

    typedef enum logic [1:0] {
        ACT_IDENTITY = 2'd0,
        ACT_RELU     = 2'd1,
        ACT_GELU     = 2'd2,
        ACT_RESERVED = 2'd3
    } act_e;

    // e = sign(x) * ((min(|x|, -b) + b)^2 + c)
    function automatic logic signed [EW-1:0] gelu_poly(
        input logic signed [DATA_W-1:0]  x,
        input logic signed [CONST_W-1:0] b,
        input logic signed [CONST_W-1:0] c
    );
        logic signed [AW-1:0] ax, nb, a;
        logic signed [SW-1:0] s;
        logic signed [EW-1:0] p;
        ax = (x < 0) ? -AW'(x) : AW'(x);
        nb = -AW'(b);
        a  = (ax < nb) ? ax : nb;
        s  = SW'(a) + SW'(b);
        p  = EW'(s) * EW'(s) + EW'(c);
        return (x < 0) ? -p : p;
    endfunction

    // r = sat(((g*mult + round) >>> shift) + add)
    function automatic logic [DATA_W-1:0] requant(
        input  logic signed [GW-1:0] g,
        input  logic        [RQ_W-1:0] mult,
        input  logic        [RQ_W-1:0] shift,
        input  logic signed [RQ_W-1:0] add,
        output logic                   sat
    );
        logic signed [MW-1:0] m, rnd, t, r;
        m   = MW'(g) * MW'($signed({1'b0, mult}));
        rnd = (shift != '0) ? (MW'(1) <<< (shift - 1'b1)) : '0;
        // Shifts this large leave |m| below the rounding point, so the
        // rounded quotient is exactly zero.
        if (int'(shift) >= int'(MW) - 1) t = '0;
        else                             t = (m + rnd) >>> shift;
        r   = t + MW'(add);
        sat = 1'b0;
        if (r > SAT_HI) begin
            r   = SAT_HI;
            sat = 1'b1;
        end else if (r < SAT_LO) begin
            r   = SAT_LO;
            sat = 1'b1;
        end
        return r[DATA_W-1:0];
    endfunction

    logic                   s1_valid, s2_valid, s3_valid;
    logic                   s1_load, s2_load, s3_load;
    act_e                   s1_mode, s2_mode, s3_mode;
    logic [DW-1:0]          s1_data, s2_data, s3_data;
    logic signed [EW-1:0]   s1_e [LANES];
    logic signed [GW-1:0]   s2_g [LANES];

    logic signed [EW-1:0]   e_next [LANES];
    logic signed [GW-1:0]   g_next [LANES];
    logic [DW-1:0]          out_next;
`ifdef ITA_ACTIVATION_STREAM_SAT_CNT_EN
    localparam int unsigned CW = $clog2(LANES + 1);
    logic [CW-1:0]          nsat_next, s3_nsat;
    logic [16:0]            sat_sum;
`endif

    // Elastic load chain: a stage loads when empty or when its successor loads.
    always_comb begin
        s3_load = !s3_valid || downstream.ready;
        s2_load = !s2_valid || s3_load;
        s1_load = !s1_valid || s2_load;
    end

    assign upstream.ready        = s1_load;
    assign downstream.valid      = s3_valid;
    assign downstream.data       = s3_data;
    assign downstream.activation = s3_mode;
    assign busy_o                = s1_valid || s2_valid || s3_valid;

    // S1 datapath: GELU polynomial per input lane.
    always_comb begin
        for (int unsigned l = 0; l < LANES; l++) begin
            e_next[l] = gelu_poly($signed(upstream.data[l*DATA_W +: DATA_W]), b_i, c_i);
        end
    end

    // S2 datapath: full precision GELU product per lane.
    always_comb begin
        for (int unsigned l = 0; l < LANES; l++) begin
            g_next[l] = GW'($signed(s1_data[l*DATA_W +: DATA_W])) * GW'(s1_e[l] + EW'(one_i));
        end
    end

    // S3 datapath: mode select, RELU clamp and GELU requantisation.
    always_comb begin
        logic [DATA_W-1:0] x;
        logic [DATA_W-1:0] rq;
        logic              sat;
        out_next = '0;
`ifdef ITA_ACTIVATION_STREAM_SAT_CNT_EN
        nsat_next = '0;
`endif
        for (int unsigned l = 0; l < LANES; l++) begin
            x  = s2_data[l*DATA_W +: DATA_W];
            rq = requant(s2_g[l], requant_mult_i, requant_shift_i, requant_add_i, sat);
            case (s2_mode)
                ACT_RELU: out_next[l*DATA_W +: DATA_W] = x[DATA_W-1] ? '0 : x;
                ACT_GELU: out_next[l*DATA_W +: DATA_W] = rq;
                default:  out_next[l*DATA_W +: DATA_W] = x;
            endcase
`ifdef ITA_ACTIVATION_STREAM_SAT_CNT_EN
            if (s2_mode == ACT_GELU && sat) nsat_next = nsat_next + 1'b1;
`endif
        end
    end

    // S1 register: captures the input beat and its polynomial.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid <= 1'b0;
            s1_mode  <= ACT_IDENTITY;
            s1_data  <= '0;
            for (int unsigned l = 0; l < LANES; l++) s1_e[l] <= '0;
        end else if (s1_load) begin
            s1_valid <= upstream.valid;
            if (upstream.valid) begin
                s1_mode <= act_e'(upstream.activation);
                s1_data <= upstream.data;
                for (int unsigned l = 0; l < LANES; l++) s1_e[l] <= e_next[l];
            end
        end
    end

    // S2 register: carries the beat with its GELU product.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_valid <= 1'b0;
            s2_mode  <= ACT_IDENTITY;
            s2_data  <= '0;
            for (int unsigned l = 0; l < LANES; l++) s2_g[l] <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_mode <= s1_mode;
                s2_data <= s1_data;
                for (int unsigned l = 0; l < LANES; l++) s2_g[l] <= g_next[l];
            end
        end
    end

    // S3 register: output flops; data holds while stalled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s3_valid <= 1'b0;
            s3_mode  <= ACT_IDENTITY;
            s3_data  <= '0;
`ifdef ITA_ACTIVATION_STREAM_SAT_CNT_EN
            s3_nsat  <= '0;
`endif
        end else if (s3_load) begin
            s3_valid <= s2_valid;
            if (s2_valid) begin
                s3_mode <= s2_mode;
                s3_data <= out_next;
`ifdef ITA_ACTIVATION_STREAM_SAT_CNT_EN
                s3_nsat <= nsat_next;
`endif
            end
        end
    end

`ifdef ITA_ACTIVATION_STREAM_SAT_CNT_EN
    assign sat_sum = 17'(sat_cnt_o) + 17'(s3_nsat);

    // Sticky saturation counter; clear wins over a same-cycle increment.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                          sat_cnt_o <= '0;
        else if (sat_clr_i)                   sat_cnt_o <= '0;
        else if (s3_valid && downstream.ready) sat_cnt_o <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end
`endif

endmodule

// File: tb/tb_ita_activation_stream.sv
// Directed self-checking bench for ita_activation_stream.
module tb_ita_activation_stream;
    localparam int unsigned LANES   = 16;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned CONST_W = 16;
    localparam int unsigned RQ_W    = 8;
    localparam int unsigned DW      = LANES * DATA_W;

    logic clk = 1'b0;
    logic rst_n;
    logic signed [CONST_W-1:0] one, b, c;
    logic        [RQ_W-1:0]    mult, shift;
    logic signed [RQ_W-1:0]    add;
    logic                      busy;
`ifdef ITA_ACTIVATION_STREAM_SAT_CNT_EN
    logic                      sat_clr;
    logic [15:0]               sat_cnt;
`endif

    ita_activation_stream_if #(.LANES(LANES), .DATA_W(DATA_W)) up_if ();
    ita_activation_stream_if #(.LANES(LANES), .DATA_W(DATA_W)) dn_if ();

    ita_activation_stream #(
        .LANES(LANES), .DATA_W(DATA_W), .CONST_W(CONST_W), .RQ_W(RQ_W)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .upstream(up_if),
        .downstream(dn_if),
        .one_i(one),
        .b_i(b),
        .c_i(c),
        .requant_mult_i(mult),
        .requant_shift_i(shift),
        .requant_add_i(add),
`ifdef ITA_ACTIVATION_STREAM_SAT_CNT_EN
        .sat_clr_i(sat_clr),
        .sat_cnt_o(sat_cnt),
`endif
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int sent_cnt = 0;
    int acc_cnt, del_cnt;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] held_data;
    bit            held_valid = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rep4(input int v0, input int v1, input int v2, input int v3);
        logic [DW-1:0] r;
        int v;
        r = '0;
        for (int l = 0; l < LANES; l++) begin
            case (l % 4)
                0: v = v0;
                1: v = v1;
                2: v = v2;
                default: v = v3;
            endcase
            r[l*DATA_W +: DATA_W] = DATA_W'(v);
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] fill(input int v);
        return rep4(v, v, v, v);
    endfunction

    // Handshake counters give the bench its own view of pipeline occupancy.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt <= 0;
            del_cnt <= 0;
        end else begin
            if (up_if.valid && up_if.ready) acc_cnt <= acc_cnt + 1;
            if (dn_if.valid && dn_if.ready) del_cnt <= del_cnt + 1;
        end
    end

    // Output monitor: ordered data, hold-while-stalled, ready/busy vs occupancy.
    always @(negedge clk) begin
        int occ;
        if (!rst_n) begin
            held_valid = 0;
        end else begin
            occ = acc_cnt - del_cnt;
            check("ready_vs_occ", DW'(up_if.ready), DW'(!(occ >= 3 && !dn_if.ready)));
            check("busy_vs_occ", DW'(busy), DW'(occ != 0));
            if (dn_if.valid && !dn_if.ready) begin
                if (held_valid) check("hold_stable", dn_if.data, held_data);
                held_valid = 1;
                held_data  = dn_if.data;
            end else begin
                held_valid = 0;
            end
            if (dn_if.valid && dn_if.ready) begin
                if (exp_q.size() == 0) check("extra_beat", DW'(1), DW'(0));
                else check("out_data", dn_if.data, exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [DW-1:0] d, input logic [1:0] m);
        bit acc = 0;
        up_if.valid = 1'b1;
        up_if.data = d;
        up_if.activation = m;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = up_if.ready;
            @(posedge clk);
            #1;
        end
        up_if.valid = 1'b0;
        if (!acc) check("send_timeout", DW'(0), DW'(1));
        else sent_cnt++;
    endtask

    task automatic expect_beat(input logic [DW-1:0] d, input logic [1:0] m, input logic [DW-1:0] e);
        exp_q.push_back(e);
        send(d, m);
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 200 && (busy || exp_q.size() != 0); i++) @(posedge clk);
        #1;
        if (i >= 200) check("idle_timeout", DW'(0), DW'(1));
    endtask

    // Counts posedges from the accepting edge (inclusive) until valid_o.
    task automatic check_latency(input string tag);
        int n = 1;
        while (!dn_if.valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, DW'(n), DW'(3));
    endtask

    initial begin
        logic [DW-1:0] sv_d [8];
        logic [1:0]    sv_m [8];
        logic [DW-1:0] sv_e [8];

        rst_n = 1'b0;
        up_if.valid = 1'b0;
        up_if.data = '0;
        up_if.activation = 2'd0;
        dn_if.ready = 1'b1;
        one = 16; b = -4; c = -16;
        mult = 1; shift = 0; add = 0;
`ifdef ITA_ACTIVATION_STREAM_SAT_CNT_EN
        sat_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid_o", DW'(dn_if.valid), DW'(0));
        check("rst_data_o", dn_if.data, '0);
        check("rst_ready_o", DW'(up_if.ready), DW'(1));
        check("rst_busy_o", DW'(busy), DW'(0));
`ifdef ITA_ACTIVATION_STREAM_SAT_CNT_EN
        check("rst_sat_cnt", DW'(sat_cnt), DW'(0));
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // RELU with extremes, plus latency.
        expect_beat(rep4(-5, 7, -128, 127), 2'd1, rep4(0, 7, 0, 127));
        check_latency("relu_latency");
        wait_idle();

        // GELU, shift 0: 2->8, -2->-56, -6->-192 clamps to -128, 1->9.
        expect_beat(rep4(2, -2, -6, 1), 2'd2, rep4(8, -56, -128, 9));
        wait_idle();

        // Reserved mode behaves as IDENTITY.
        expect_beat(fill(-9), 2'd3, fill(-9));
        expect_beat(fill(-9), 2'd0, fill(-9));
        wait_idle();

        // Rounding shift and add: (8+2)>>2+3=5, (-56+2)>>>2+3=-11, (-192+2)>>>2+3=-45, (9+2)>>2+3=5.
        shift = 2; add = 3;
        expect_beat(rep4(2, -2, -6, 1), 2'd2, rep4(5, -11, -45, 5));
        wait_idle();
        shift = 0; add = 0;

        // Saturation: 8*127=1016 -> 127 on every lane.
        mult = 127;
`ifdef ITA_ACTIVATION_STREAM_SAT_CNT_EN
        sat_clr = 1'b1;
        @(posedge clk);
        #1;
        sat_clr = 1'b0;
`endif
        expect_beat(fill(2), 2'd2, fill(127));
        wait_idle();
`ifdef ITA_ACTIVATION_STREAM_SAT_CNT_EN
        check("sat_cnt_lanes", DW'(sat_cnt), DW'(LANES));
        sat_clr = 1'b1;
        @(posedge clk);
        #1;
        sat_clr = 1'b0;
        check("sat_cnt_clear", DW'(sat_cnt), DW'(0));
`endif
        mult = 1;

        // Mixed-mode stream with a 5-cycle downstream stall.
        sv_d = '{fill(-9), fill(-3), fill(2),   fill(100), fill(45), fill(-2),   fill(-128), fill(1)};
        sv_m = '{2'd0,     2'd1,     2'd2,      2'd0,      2'd1,     2'd2,       2'd0,       2'd1};
        sv_e = '{fill(-9), fill(0),  fill(8),   fill(100), fill(45), fill(-56),  fill(-128), fill(1)};
        sent_cnt = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) expect_beat(sv_d[i], sv_m[i], sv_e[i]);
            end
            begin
                for (int i = 0; i < 100 && sent_cnt < 3; i++) @(posedge clk);
                #1;
                dn_if.ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                dn_if.ready = 1'b1;
            end
        join
        wait_idle();

        // Reset with three beats in flight: everything is discarded.
        dn_if.ready = 1'b0;
        send(fill(33), 2'd0);
        send(fill(-44), 2'd1);
        send(fill(55), 2'd0);
        @(posedge clk);
        #1;
        check("pre_rst_valid", DW'(dn_if.valid), DW'(1));
        rst_n = 1'b0;
        #1;
        check("midrst_valid_o", DW'(dn_if.valid), DW'(0));
        check("midrst_data_o", dn_if.data, '0);
        check("midrst_busy_o", DW'(busy), DW'(0));
        check("midrst_ready_o", DW'(up_if.ready), DW'(1));
        @(negedge clk);
        rst_n = 1'b1;
        dn_if.ready = 1'b1;
        @(posedge clk);
        #1;
        expect_beat(fill(-7), 2'd1, fill(0));
        check_latency("post_rst_latency");
        wait_idle();

        check("queue_drained", DW'(exp_q.size()), DW'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
